// File: rtl/gpo_core_fifo.sv
// Timestamp-matched GPO core with a DEPTH-entry output queue, override mode and drop reporting.
// Optional build macro GPO_FLUSH_ON_OVERRIDE_EN: discard queued words when override mode is entered.
module gpo_core_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int OVR_WIDTH  = 64,
  parameter int DEPTH      = 4,
  parameter int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  override_en,
  input  logic [OVR_WIDTH-1:0]  override_value,
  input  logic                  counter_matched,
  input  logic [DATA_WIDTH-1:0] gpo_in,
  input  logic                  busy,
  output logic                  selected,
  output logic [DATA_WIDTH-1:0] gpo_out,
  output logic                  overrided,
  output logic                  busy_error,
  output logic [DATA_WIDTH-1:0] error_data,
  output logic [LVL_W-1:0]      fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {
    NORMAL   = 1'b0,
    OVERRIDE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [OVR_WIDTH-1:0]   ovr_q;
  logic [DATA_WIDTH-1:0]  out_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0]  head;

  logic in_normal, ovr_block, empty, full;
  logic enter_ovr, latch_ovr;
  logic push_req, bypass, pop, push_fifo, drop_full, drop_ovr;
  logic flush, flush_drop;

  // ---------------------------------------------------------------------------
  // Decode of this cycle's queue actions
  // ---------------------------------------------------------------------------
  assign in_normal = (state_q == NORMAL);
  assign ovr_block = override_en || !in_normal;
  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == LVL_FULL);
  assign head      = mem[rd_ptr];

  assign enter_ovr = in_normal && override_en && !busy;
  assign latch_ovr = in_normal ? enter_ovr : !busy;

  assign push_req  = in_normal && counter_matched && !override_en;
  assign drop_ovr  = counter_matched && ovr_block;
  assign bypass    = push_req && empty && !busy;
  assign pop       = !ovr_block && !busy && !empty;
  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign push_fifo = push_req && !bypass && (!full || pop);
  assign drop_full = push_req && full && !pop;

`ifdef GPO_FLUSH_ON_OVERRIDE_EN
  assign flush      = enter_ovr;
  assign flush_drop = enter_ovr && !empty;
`else
  assign flush      = 1'b0;
  assign flush_drop = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:   if (enter_ovr)    state_d = OVERRIDE;
      OVERRIDE: if (!override_en) state_d = NORMAL;
      default:                    state_d = NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORMAL;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ovr) ovr_q <= override_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage and pointers
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; validity is carried entirely by the
  // pointers and fifo_level, and a reset would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (push_fifo) mem[wr_ptr] <= gpo_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      fifo_level <= '0;
    end else begin
      if (push_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fifo, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, status pulses and error capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q      <= '0;
      selected   <= 1'b0;
      overrided  <= 1'b0;
      busy_error <= 1'b0;
      error_data <= '0;
    end else begin
      if (bypass)   out_q <= gpo_in;
      else if (pop) out_q <= head;
      selected   <= bypass || pop;
      overrided  <= drop_ovr || flush_drop;
      busy_error <= drop_full;
      // A word dropped this cycle is more recent than a flushed head.
      if (drop_ovr || drop_full) error_data <= gpo_in;
      else if (flush_drop)       error_data <= head;
    end
  end

  assign gpo_out = (state_q == OVERRIDE) ? DATA_WIDTH'(ovr_q) : out_q;

endmodule

// File: tb/tb_gpo_core_fifo.sv
// Directed self-checking bench for gpo_core_fifo (default parameters, DEPTH=4).
// Honours GPO_FLUSH_ON_OVERRIDE_EN when the design is built with it.
module tb_gpo_core_fifo;

  localparam int DW = 128;
  localparam int OW = 64;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          override_en;
  logic [OW-1:0] override_value;
  logic          counter_matched;
  logic [DW-1:0] gpo_in;
  logic          busy;
  logic          selected;
  logic [DW-1:0] gpo_out;
  logic          overrided;
  logic          busy_error;
  logic [DW-1:0] error_data;
  logic [LW-1:0] fifo_level;

  int tests_run = 0;
  int tests_failed = 0;

  gpo_core_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .override_en    (override_en),
    .override_value (override_value),
    .counter_matched(counter_matched),
    .gpo_in         (gpo_in),
    .busy           (busy),
    .selected       (selected),
    .gpo_out        (gpo_out),
    .overrided      (overrided),
    .busy_error     (busy_error),
    .error_data     (error_data),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    counter_matched = 1'b1;
    gpo_in = w;
    tick();
    counter_matched = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    override_en = 1'b0;
    override_value = '0;
    counter_matched = 1'b0;
    gpo_in = '0;
    busy = 1'b0;
    #3;
    check("rst_gpo_out", gpo_out, 0);
    check("rst_level", DW'(fifo_level), 0);
    check("rst_selected", DW'(selected), 0);
    check("rst_overrided", DW'(overrided), 0);
    check("rst_busy_error", DW'(busy_error), 0);
    check("rst_error_data", error_data, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Bypass into an empty queue
    push(128'hA5);
    check("byp_gpo_out", gpo_out, 128'hA5);
    check("byp_selected", DW'(selected), 1);
    check("byp_level", DW'(fifo_level), 0);
    tick();
    check("byp_sel_pulse", DW'(selected), 0);

    // Queue three words while busy, then drain
    busy = 1'b1;
    push(1); push(2); push(3);
    check("q3_level", DW'(fifo_level), 3);
    check("q3_gpo_hold", gpo_out, 128'hA5);
    check("q3_selected", DW'(selected), 0);
    busy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("drain3_out%0d", k), gpo_out, DW'(k));
      check($sformatf("drain3_sel%0d", k), DW'(selected), 1);
      check($sformatf("drain3_lvl%0d", k), DW'(fifo_level), DW'(3 - k));
    end
    tick();
    check("drain3_sel_end", DW'(selected), 0);

    // Overflow: five words into four slots
    busy = 1'b1;
    push(1); push(2); push(3); push(4);
    check("full_level", DW'(fifo_level), 4);
    check("full_no_err", DW'(busy_error), 0);
    push(5);
    check("ovf_busy_error", DW'(busy_error), 1);
    check("ovf_error_data", error_data, 5);
    check("ovf_level", DW'(fifo_level), 4);
    check("ovf_overrided", DW'(overrided), 0);
    tick();
    check("ovf_pulse_end", DW'(busy_error), 0);

    // Full queue, simultaneous push and pop
    busy = 1'b0;
    push(6);
    check("pp_gpo_out", gpo_out, 1);
    check("pp_selected", DW'(selected), 1);
    check("pp_no_err", DW'(busy_error), 0);
    check("pp_level", DW'(fifo_level), 4);
    tick(); check("pp_d2", gpo_out, 2); check("pp_l3", DW'(fifo_level), 3);
    tick(); check("pp_d3", gpo_out, 3);
    tick(); check("pp_d4", gpo_out, 4);
    tick(); check("pp_d6", gpo_out, 6); check("pp_l0", DW'(fifo_level), 0);
    tick();

    // Override entry and a matched word dropped during override
    override_en = 1'b1;
    override_value = 64'hDEAD;
    tick();
    check("ovr_gpo_out", gpo_out, 128'hDEAD);
    check("ovr_selected", DW'(selected), 0);
    push(7);
    check("ovr_overrided", DW'(overrided), 1);
    check("ovr_error_data", error_data, 7);
    check("ovr_level", DW'(fifo_level), 0);
    check("ovr_no_busy_err", DW'(busy_error), 0);
    override_value = 64'hFFFF_0000_1234_5678;
    tick();
    check("ovr_pulse_end", DW'(overrided), 0);
    check("ovr_relatch", gpo_out, 128'hFFFF_0000_1234_5678);
    override_en = 1'b0;
    tick();
    check("ovr_exit_out", gpo_out, 6);

    // Two words queued across an override window
    busy = 1'b1;
    push(8); push(9);
    check("ovq_level", DW'(fifo_level), 2);
    busy = 1'b0;
    override_en = 1'b1;
    override_value = 64'hBEEF;
    tick();
    check("ovq_gpo_out", gpo_out, 128'hBEEF);
`ifdef GPO_FLUSH_ON_OVERRIDE_EN
    check("ovq_flush_level", DW'(fifo_level), 0);
    check("ovq_flush_pulse", DW'(overrided), 1);
    check("ovq_flush_data", error_data, 8);
    tick();
    check("ovq_flush_pulse_end", DW'(overrided), 0);
    override_en = 1'b0;
    tick();
    check("ovq_exit_out", gpo_out, 6);
    tick();
    check("ovq_exit_level", DW'(fifo_level), 0);
    check("ovq_exit_sel", DW'(selected), 0);
`else
    check("ovq_kept_level", DW'(fifo_level), 2);
    check("ovq_no_pulse", DW'(overrided), 0);
    tick();
    check("ovq_held_level", DW'(fifo_level), 2);
    override_en = 1'b0;
    tick();
    check("ovq_exit_out", gpo_out, 6);
    tick();
    check("ovq_drain8", gpo_out, 8);
    check("ovq_lvl1", DW'(fifo_level), 1);
    tick();
    check("ovq_drain9", gpo_out, 9);
    check("ovq_lvl0", DW'(fifo_level), 0);
`endif
    tick();

    // Asynchronous reset in the middle of a drain
    busy = 1'b1;
    push(10); push(11); push(12);
    busy = 1'b0;
    tick();
    check("md_gpo_out", gpo_out, 10);
    check("md_level", DW'(fifo_level), 2);
    #2;
    reset = 1'b0;
    #1;
    check("ar_gpo_out", gpo_out, 0);
    check("ar_level", DW'(fifo_level), 0);
    check("ar_selected", DW'(selected), 0);
    check("ar_error_data", error_data, 0);
    #1;
    reset = 1'b1;
    tick();
    check("ar_post_level", DW'(fifo_level), 0);
    check("ar_post_out", gpo_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
